acc_cpu_gen2: RTL

Parametrised second-generation accumulator CPU datapath. It executes one instruction per valid/ready handshake: 4-bit opcode plus OPND_W-bit operand.
- Keeps the first-generation encoding: opcode 0 = ADD, opcode 1 = SUB.
- Adds flags, logic/shift ops, a small register bank, carry-chained arithmetic and a multi-cycle multiply.
- Sits between the instruction sequencer and the result/observation logic.

---
 rtl/acc_cpu_pkg.sv | 32 +++
 rtl/acc_cpu_mul_seq.sv | 45 ++++
 rtl/acc_cpu_gen2.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared opcode, flag and state definitions for the
// second-generation accumulator CPU.
package acc_cpu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_LDA = 4'h9;
  localparam logic [3:0] OP_STA = 4'hA;
  localparam logic [3:0] OP_ADC = 4'hB;
  localparam logic [3:0] OP_SBB = 4'hC;
  localparam logic [3:0] OP_NOP = 4'hD;
  localparam logic [3:0] OP_CLR = 4'hE;
  localparam logic [3:0] OP_ILL = 4'hF;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

endpackage

// File: rtl/acc_cpu_mul_seq.sv
// Unsigned shift-add multiplier, one multiplier bit per clock.
// done is high on the edge that retires the last partial product.
module acc_cpu_mul_seq #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] mcand;
  logic [2*DATA_W-1:0] part;
  logic [DATA_W-1:0]   mplier;

  // product includes the step being taken this cycle
  assign product = part + (mplier[0] ? mcand : '0);
  assign done    = (cnt == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      mcand  <= '0;
      part   <= '0;
      mplier <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(DATA_W);
      mcand  <= {{DATA_W{1'b0}}, a};
      part   <= '0;
      mplier <= b;
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_W'(1);
      mcand  <= mcand << 1;
      part   <= product;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/acc_cpu_gen2.sv
// Accumulator CPU datapath: flags, logic/shift ops, register bank,
// carry-chained arithmetic and a sequential multiply.
module acc_cpu_gen2
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OPND_W = 4,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OPND_W+3:0] instruction,
  output logic [DATA_W-1:0] acc,
  output logic [3:0]        flags,
  output logic              busy,
  output logic              retire,
  output logic              illegal
);

  localparam int IDX_W = $clog2(NREGS);
  localparam int MSB   = DATA_W - 1;

  state_t state, state_nxt;

  logic [DATA_W-1:0]   bank [NREGS];
  logic [3:0]          opcode;
  logic [DATA_W-1:0]   opnd;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   amt;
  logic [DATA_W:0]     add_r;
  logic [DATA_W:0]     sub_r;
  logic [DATA_W:0]     shl_r;
  logic [DATA_W:0]     shr_r;
  logic                cin;
  logic                add_v;
  logic                sub_v;
  logic                accept;
  logic                mul_start;
  logic                mul_done;
  logic [2*DATA_W-1:0] product;
  logic [DATA_W-1:0]   acc_nxt;
  logic [3:0]          flg_nxt;
  logic                wr_en;
  logic                ret_nxt;
  logic                ill_nxt;
  logic                zn_upd;

  assign opcode      = instruction[OPND_W+3 -: 4];
  assign opnd        = DATA_W'(instruction[OPND_W-1:0]);
  assign idx         = instruction[IDX_W-1:0];
  assign instr_ready = (state == ST_IDLE);
  assign busy        = (state == ST_MUL);
  assign accept      = instr_valid && instr_ready;

  assign cin   = flags[FLG_C] &&
                 ((opcode == OP_ADC) || (opcode == OP_SBB));
  assign add_r = {1'b0, acc} + {1'b0, opnd}
               + {{DATA_W{1'b0}}, cin};
  assign sub_r = {1'b0, acc} - {1'b0, opnd}
               - {{DATA_W{1'b0}}, cin};
  assign add_v = (acc[MSB] == opnd[MSB]) &&
                 (add_r[MSB] != acc[MSB]);
  assign sub_v = (acc[MSB] != opnd[MSB]) &&
                 (sub_r[MSB] != acc[MSB]);

  // the extra bit catches the last bit shifted out
  assign amt   = DATA_W'(opnd % DATA_W);
  assign shl_r = {1'b0, acc} << amt;
  assign shr_r = {acc, 1'b0} >> amt;

  acc_cpu_mul_seq #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (acc),
    .b       (opnd),
    .done    (mul_done),
    .product (product)
  );

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    flg_nxt   = flags;
    wr_en     = 1'b0;
    ret_nxt   = 1'b0;
    ill_nxt   = 1'b0;
    mul_start = 1'b0;
    zn_upd    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          ret_nxt = 1'b1;
          zn_upd  = 1'b1;
          unique case (opcode)
            OP_ADD, OP_ADC: begin
              acc_nxt        = add_r[MSB:0];
              flg_nxt[FLG_C] = add_r[DATA_W];
              flg_nxt[FLG_V] = add_v;
            end
            OP_SUB, OP_SBB: begin
              acc_nxt        = sub_r[MSB:0];
              flg_nxt[FLG_C] = sub_r[DATA_W];
              flg_nxt[FLG_V] = sub_v;
            end
            OP_AND: begin
              acc_nxt        = acc & opnd;
              flg_nxt[FLG_C] = 1'b0;
              flg_nxt[FLG_V] = 1'b0;
            end
            OP_OR: begin
              acc_nxt        = acc | opnd;
              flg_nxt[FLG_C] = 1'b0;
              flg_nxt[FLG_V] = 1'b0;
            end
            OP_XOR: begin
              acc_nxt        = acc ^ opnd;
              flg_nxt[FLG_C] = 1'b0;
              flg_nxt[FLG_V] = 1'b0;
            end
            OP_LDI: acc_nxt = opnd;
            OP_SHL: begin
              acc_nxt        = shl_r[MSB:0];
              flg_nxt[FLG_C] = shl_r[DATA_W];
              flg_nxt[FLG_V] = 1'b0;
            end
            OP_SHR: begin
              acc_nxt        = shr_r[DATA_W:1];
              flg_nxt[FLG_C] = shr_r[0];
              flg_nxt[FLG_V] = 1'b0;
            end
            OP_MUL: begin
              state_nxt = ST_MUL;
              mul_start = 1'b1;
              ret_nxt   = 1'b0;
              zn_upd    = 1'b0;
            end
            OP_LDA: acc_nxt = bank[idx];
            OP_STA: begin
              wr_en  = 1'b1;
              zn_upd = 1'b0;
            end
            OP_NOP: zn_upd = 1'b0;
            OP_CLR: begin
              acc_nxt = '0;
              flg_nxt = 4'b0001;
            end
            default: begin
              ill_nxt = 1'b1;
              zn_upd  = 1'b0;
            end
          endcase
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_nxt      = ST_IDLE;
          acc_nxt        = product[MSB:0];
          flg_nxt[FLG_C] = |product[2*DATA_W-1:DATA_W];
          flg_nxt[FLG_V] = 1'b0;
          zn_upd         = 1'b1;
          ret_nxt        = 1'b1;
        end
      end
    endcase
    if (zn_upd) begin
      flg_nxt[FLG_Z] = (acc_nxt == '0);
      flg_nxt[FLG_N] = acc_nxt[MSB];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      acc     <= '0;
      flags   <= '0;
      retire  <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      flags   <= flg_nxt;
      retire  <= ret_nxt;
      illegal <= ill_nxt;
      if (wr_en) bank[idx] <= acc;
    end
  end

endmodule
